ram_responder: RTL
==================

# ram_responder

Behavioural-but-synthesisable word-addressed backing memory that answers the external RAM interface driven by the cache controllers. It accepts one read or write request at a time, holds it for a fixed access latency, then commits or returns the word and pulses `ram_data_valid`. Benches instantiate it under every cache variant, and it also serves as the on-chip scratch RAM model for FPGA bring-up.

## Interface
- `ADDRESS_WIDTH`, 16: byte address width; must match the attached cache.
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 4: access latency in cycles; must be ≥ 1, else `$fatal`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ram_address`  in  ADDRESS_WIDTH: byte address; bits [1:0] are ignored.
- `ram_rd`  in  1: read request, level.
- `ram_wr`  in  1: write request, level.
- `ram_data_wr`  in  32: write data; full word, with no byte enables.
- `ram_data_rd`  out  32: read data; valid while `ram_data_valid` is high.
- `ram_data_valid`  out  1: one-cycle completion pulse for both reads and writes.

## Operation
- Word index is `ram_address[2 +: log2(DEPTH_WORDS)]`. Higher address bits are ignored, so addresses alias modulo DEPTH_WORDS.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - On a clock edge with `ram_rd | ram_wr`, capture the op, word index and `ram_data_wr`.
  - Load the counter with `LATENCY-1` (plus jitter, see Configuration) and go to WAIT.
  - If `ram_rd` and `ram_wr` are both high, the request is treated as a write.
- WAIT:
  - If the counter is 0, go to RESPOND; otherwise decrement.
  - On the WAIT→RESPOND edge:
    - a read loads `ram_data_rd` from the array;
    - a write commits the captured data to the array, and `ram_data_rd` is unchanged.
- RESPOND:
  - `ram_data_valid` is 1 for exactly this one cycle.
  - The next state is always IDLE.
- Request inputs are sampled only in IDLE. Changes during WAIT/RESPOND are ignored, because the request is fully captured at accept.
- The requester must deassert or replace its request at the edge that ends RESPOND. The IDLE cycle that follows samples the fresh request, so there is no double acceptance.
- Counter width is `$clog2(LATENCY+4)` bits, enough for the maximum jitter.
- Array contents are not affected by reset and power up undefined (X in simulation). Benches preload them via hierarchical `$readmemh`.

## Timing
- Reset values: `ram_data_valid`=0, `ram_data_rd`=0, state=IDLE, counter=0.
- Request-to-response latency: if the request is accepted at edge E0, `ram_data_valid` rises after edge E0+LATENCY.
  - With LATENCY=1, valid is high in the cycle after the accept edge.
- Back-to-back throughput: one access per LATENCY+2 cycles (accept edge, LATENCY cycles, one IDLE cycle).
- Read-after-write to the same word returns the new data. The write commits before the write's valid pulse, so any later read sees it.
- Reset asserted mid-WAIT:
  - the FSM returns to IDLE and valid goes 0 immediately (asynchronously);
  - a pending write is discarded (not committed);
  - the array keeps its prior contents.
- Reset deassertion: the first request can be accepted on the first rising edge after `rst` goes high.

## Configuration
- `RAM_RESPONDER_JITTER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clock.
  - At accept, the counter loads `LATENCY-1 + lfsr[1:0]`, so latency varies from LATENCY to LATENCY+3.
  - Used to stress cache fill/writeback ordering.
- Undefined: no LFSR logic; latency is exactly LATENCY.
- All directed tests below run with the macro undefined.

## Test plan
- Reset with LATENCY=4, then hold `ram_rd`=1 with address 0x0010 (word[4] preloaded 0xDEADBEEF) -> valid is a single pulse 4 cycles after the accept edge, `ram_data_rd`=0xDEADBEEF.
- Write 0x12345678 to 0x0020, then read 0x0020 -> write valid pulse after 4 cycles; read returns 0x12345678; throughput is one access per 6 cycles.
- `ram_rd`=`ram_wr`=1 at 0x0004 with data 0xA5A5A5A5, then read 0x0004 -> treated as write; read returns 0xA5A5A5A5.
- DEPTH_WORDS=1024, write 0xCAFEF00D to 0x1000, then read 0x0000 -> returns 0xCAFEF00D (alias wrap).
- Write 0x11111111 to 0x0008, pulse `rst` low during WAIT, then read 0x0008 -> valid 0 during reset; read returns the preloaded old value, not 0x11111111.
- LATENCY=1 with the request held continuously across 3 reads of addresses 0, 4, 8 -> valid pulses at cycles 1, 4, 7 with the correct data each time.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word-addressed backing RAM that answers one request at a time after a fixed access latency.
// Build macro RAM_RESPONDER_JITTER_EN adds 0..3 cycles of LFSR-driven latency jitter per access.
module ram_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DEPTH_WORDS   = 1024,
    parameter int LATENCY       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [31:0]              ram_data_wr,
    output logic [31:0]              ram_data_rd,
    output logic                     ram_data_valid
);

    localparam int INDEX_W = $clog2(DEPTH_WORDS);
    localparam int COUNT_W = $clog2(LATENCY + 4);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    if (LATENCY < 1) begin : g_bad_latency
        $fatal(1, "ram_responder: LATENCY must be >= 1");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $fatal(1, "ram_responder: DEPTH_WORDS must be a power of two >= 2");
    end
    if (ADDRESS_WIDTH < INDEX_W + 2) begin : g_bad_addr
        $fatal(1, "ram_responder: ADDRESS_WIDTH too small for DEPTH_WORDS");
    end

    logic [1:0]         state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_load;
    logic               op_write;
    logic [INDEX_W-1:0] index_q;
    logic [31:0]        wdata_q;
    logic               accept;
    logic               commit;
    logic               unused_addr;

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane bits and bits above the word index are intentionally ignored (addresses alias).
    assign unused_addr = ^ram_address;

    assign accept = (state == IDLE) && (ram_rd || ram_wr);
    assign commit = (state == WAIT) && (count == '0);

`ifdef RAM_RESPONDER_JITTER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running so each accept sees a different draw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign count_load = COUNT_W'(LATENCY - 1) + COUNT_W'(lfsr[1:0]);
`else
    assign count_load = COUNT_W'(LATENCY - 1);
`endif

    // Request capture and array write; the array is never reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= ram_wr;
            index_q  <= ram_address[2 +: INDEX_W];
            wdata_q  <= ram_data_wr;
        end
        if (commit && op_write) begin
            mem[index_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            count          <= '0;
            ram_data_valid <= 1'b0;
            ram_data_rd    <= '0;
        end else begin
            ram_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_rd || ram_wr) begin
                        state <= WAIT;
                        count <= count_load;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        state          <= RESPOND;
                        ram_data_valid <= 1'b1;
                        if (!op_write) begin
                            ram_data_rd <= mem[index_q];
                        end
                    end else begin
                        count <= count - COUNT_W'(1);
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
